// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//
// Pipelined immediate generator for the decode stage. One instruction per
// cycle enters on a valid/ready handshake. The opcode is classified into
// I/S/B/U/J, and the sign-extended XLEN-bit immediate is produced. OP-IMM and
// OP-IMM-32 shifts instead yield a zero-extended shift amount. Unknown opcodes
// are flagged as illegal and still forwarded downstream.
//
// A main output register (M) and a skid register (K) give full throughput
// under backpressure while in_ready stays a plain flop.
//
// Build option:
//   IMM_GEN_UJ_EN  defined   : U (LUI/AUIPC) and J (JAL) formats are decoded.
//                  undefined : U/J opcodes are reported as illegal.
//
// Parameters:
//   XLEN         immediate width, 32 or 64
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     input instruction valid
//   in_ready     block can accept (registered)
//   in_instr     32-bit instruction word
//   out_valid    output holds a result
//   out_ready    consumer accepts the result
//   out_instr    instruction word passed through unchanged
//   out_imm      generated immediate, XLEN bits
//   out_fmt      0 I, 1 S, 2 B, 3 U, 4 J, 7 none
//   out_illegal  opcode not recognised
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  localparam logic [2:0] FMT_I    = 3'd0;
  localparam logic [2:0] FMT_S    = 3'd1;
  localparam logic [2:0] FMT_B    = 3'd2;
  localparam logic [2:0] FMT_U    = 3'd3;
  localparam logic [2:0] FMT_J    = 3'd4;
  localparam logic [2:0] FMT_NONE = 3'd7;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ---------------------------------------------------------------------------
  // Immediate field extraction. Each builder returns a 32-bit value that is
  // already sign-extended from bit 31 of the instruction; widening to XLEN
  // then only needs a signed size cast.
  // ---------------------------------------------------------------------------
  function automatic logic signed [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic signed [31:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic signed [31:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic signed [31:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'b0};
  endfunction

  function automatic logic signed [31:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  function automatic logic signed [XLEN-1:0] sext_xlen(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  // Shift amounts are unsigned; funct7 above the shamt field never leaks in.
  function automatic logic signed [XLEN-1:0] zext_shamt(input logic [5:0] s);
    logic [XLEN-1:0] z;
    z      = '0;
    z[5:0] = s;
    return $signed(z);
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0: combinational decode of the incoming word
  // ---------------------------------------------------------------------------
  logic [6:0]             op_p0;
  logic [2:0]             f3_p0;
  logic                   is_shift_p0;
  logic [5:0]             shamt_p0;
  logic signed [XLEN-1:0] dec_imm_p0;
  logic [2:0]             dec_fmt_p0;
  logic                   dec_ill_p0;

  assign op_p0       = in_instr[6:0];
  assign f3_p0       = in_instr[14:12];
  assign is_shift_p0 = (f3_p0 == 3'b001) || (f3_p0 == 3'b101);
  // RV64 OP-IMM shifts carry a 6-bit shamt; RV32 and the *W forms use 5 bits.
  assign shamt_p0    = (XLEN == 64) ? in_instr[25:20] : {1'b0, in_instr[24:20]};

  always_comb begin
    dec_imm_p0 = '0;
    dec_fmt_p0 = FMT_NONE;
    dec_ill_p0 = 1'b1;
    case (op_p0)
      OP_IMM: begin
        dec_fmt_p0 = FMT_I;
        dec_ill_p0 = 1'b0;
        dec_imm_p0 = is_shift_p0 ? zext_shamt(shamt_p0) : sext_xlen(imm_i(in_instr));
      end
      OP_LOAD, OP_JALR: begin
        dec_fmt_p0 = FMT_I;
        dec_ill_p0 = 1'b0;
        dec_imm_p0 = sext_xlen(imm_i(in_instr));
      end
      OP_IMM32: begin
        // OP-IMM-32 only exists on RV64; on RV32 it stays illegal.
        if (XLEN == 64) begin
          dec_fmt_p0 = FMT_I;
          dec_ill_p0 = 1'b0;
          dec_imm_p0 = is_shift_p0 ? zext_shamt({1'b0, in_instr[24:20]})
                                   : sext_xlen(imm_i(in_instr));
        end
      end
      OP_STORE: begin
        dec_fmt_p0 = FMT_S;
        dec_ill_p0 = 1'b0;
        dec_imm_p0 = sext_xlen(imm_s(in_instr));
      end
      OP_BRANCH: begin
        dec_fmt_p0 = FMT_B;
        dec_ill_p0 = 1'b0;
        dec_imm_p0 = sext_xlen(imm_b(in_instr));
      end
`ifdef IMM_GEN_UJ_EN
      OP_LUI, OP_AUIPC: begin
        dec_fmt_p0 = FMT_U;
        dec_ill_p0 = 1'b0;
        dec_imm_p0 = sext_xlen(imm_u(in_instr));
      end
      OP_JAL: begin
        dec_fmt_p0 = FMT_J;
        dec_ill_p0 = 1'b0;
        dec_imm_p0 = sext_xlen(imm_j(in_instr));
      end
`endif
      default: begin
        dec_imm_p0 = '0;
        dec_fmt_p0 = FMT_NONE;
        dec_ill_p0 = 1'b1;
      end
    endcase
  end

`ifndef IMM_GEN_UJ_EN
  // U/J builders are unused in this build; keep them referenced so the
  // extraction logic stays in one place for both configurations.
  logic signed [31:0] uj_unused_p0;
  assign uj_unused_p0 = imm_u(in_instr) ^ imm_j(in_instr);
  logic               uj_unused_red_p0;
  assign uj_unused_red_p0 = ^uj_unused_p0 & (op_p0 == OP_LUI) & (op_p0 == OP_AUIPC)
                            & (op_p0 == OP_JAL) & 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Stage p1: main register M and skid register K
  // ---------------------------------------------------------------------------
  logic                   m_vld_p1, k_vld_p1;
  logic [31:0]            m_instr_p1, k_instr_p1;
  logic signed [XLEN-1:0] m_imm_p1, k_imm_p1;
  logic [2:0]             m_fmt_p1, k_fmt_p1;
  logic                   m_ill_p1, k_ill_p1;
  logic                   in_ready_q;

  logic accept, consume, to_m, to_k, k_to_m;
  logic m_vld_nxt, k_vld_nxt;

  assign accept  = in_valid && in_ready_q;
  assign consume = m_vld_p1 && out_ready;
  // New word lands in M when M is free now or is being emptied with nothing
  // waiting in K; otherwise it must queue behind M in K.
  assign to_m    = accept && (!m_vld_p1 || (consume && !k_vld_p1));
  assign to_k    = accept && !to_m;
  assign k_to_m  = consume && k_vld_p1;

  assign m_vld_nxt = to_m || k_to_m || (m_vld_p1 && !consume);
  assign k_vld_nxt = to_k || (k_vld_p1 && !consume);

  // Control state, plus M's data whose reset value is visible on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld_p1   <= 1'b0;
      k_vld_p1   <= 1'b0;
      in_ready_q <= 1'b1;
      m_instr_p1 <= '0;
      m_imm_p1   <= '0;
      m_fmt_p1   <= FMT_NONE;
      m_ill_p1   <= 1'b0;
    end else begin
      m_vld_p1   <= m_vld_nxt;
      k_vld_p1   <= k_vld_nxt;
      in_ready_q <= !k_vld_nxt;
      if (k_to_m) begin
        m_instr_p1 <= k_instr_p1;
        m_imm_p1   <= k_imm_p1;
        m_fmt_p1   <= k_fmt_p1;
        m_ill_p1   <= k_ill_p1;
      end else if (to_m) begin
        m_instr_p1 <= in_instr;
        m_imm_p1   <= dec_imm_p0;
        m_fmt_p1   <= dec_fmt_p0;
        m_ill_p1   <= dec_ill_p0;
      end
    end
  end

  // K payload is only meaningful while k_vld_p1 is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (to_k) begin
      k_instr_p1 <= in_instr;
      k_imm_p1   <= dec_imm_p0;
      k_fmt_p1   <= dec_fmt_p0;
      k_ill_p1   <= dec_ill_p0;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = m_vld_p1;
  assign out_instr   = m_instr_p1;
  assign out_imm     = m_imm_p1;
  assign out_fmt     = m_fmt_p1;
  assign out_illegal = m_ill_p1;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // XLEN=32 instance
  logic        iv32 = 1'b0, ir32, ov32, or32 = 1'b1, ill32;
  logic [31:0] ii32 = '0, oi32, om32;
  logic [2:0]  of32;

  // XLEN=64 instance
  logic        iv64 = 1'b0, ir64, ov64, or64 = 1'b1, ill64;
  logic [31:0] ii64 = '0, oi64;
  logic [63:0] om64;
  logic [2:0]  of64;

  imm_gen_pipe #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv32), .in_ready(ir32), .in_instr(ii32),
    .out_valid(ov32), .out_ready(or32), .out_instr(oi32),
    .out_imm(om32), .out_fmt(of32), .out_illegal(ill32)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv64), .in_ready(ir64), .in_instr(ii64),
    .out_valid(ov64), .out_ready(or64), .out_instr(oi64),
    .out_imm(om64), .out_fmt(of64), .out_illegal(ill64)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    bit          w64;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic        rdy, vld, ill;
    logic [31:0] ins;
    logic [63:0] imm;
    logic [2:0]  fmt;
    @(negedge clk);
    if (v.w64) begin iv64 = 1'b1; ii64 = v.instr; end
    else       begin iv32 = 1'b1; ii32 = v.instr; end
    rdy = v.w64 ? ir64 : ir32;
    chk($sformatf("v%0d_in_ready", idx), {63'b0, rdy}, 64'd1);
    @(posedge clk);
    #1;
    iv32 = 1'b0;
    iv64 = 1'b0;
    vld = v.w64 ? ov64 : ov32;
    ins = v.w64 ? oi64 : oi32;
    imm = v.w64 ? om64 : {32'b0, om32};
    fmt = v.w64 ? of64 : of32;
    ill = v.w64 ? ill64 : ill32;
    chk($sformatf("v%0d_valid", idx), {63'b0, vld}, 64'd1);
    chk($sformatf("v%0d_instr", idx), {32'b0, ins}, {32'b0, v.instr});
    chk($sformatf("v%0d_imm", idx), imm, v.imm);
    chk($sformatf("v%0d_fmt", idx), {61'b0, fmt}, {61'b0, v.fmt});
    chk($sformatf("v%0d_ill", idx), {63'b0, ill}, {63'b0, v.ill});
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] bp [4];
    logic [31:0] got [$];
    int idx;
    bit acc, leak, stale;

    // ---------------- directed vector table ----------------
    vecs.push_back('{32'hFFF00093, 64'h0000_0000_FFFF_FFFF, 3'd0, 1'b0, 1'b0}); // addi -1
    vecs.push_back('{32'hFE112E23, 64'h0000_0000_FFFF_FFFC, 3'd1, 1'b0, 1'b0}); // sw -4
    vecs.push_back('{32'hFE000CE3, 64'h0000_0000_FFFF_FFF8, 3'd2, 1'b0, 1'b0}); // beq -8
    vecs.push_back('{32'h4030D093, 64'h0000_0000_0000_0003, 3'd0, 1'b0, 1'b0}); // srai 3
    vecs.push_back('{32'h02109093, 64'h0000_0000_0000_0001, 3'd0, 1'b0, 1'b0}); // slli, bit25 excluded
    vecs.push_back('{32'h00402083, 64'h0000_0000_0000_0004, 3'd0, 1'b0, 1'b0}); // lw 4
    vecs.push_back('{32'h800080E7, 64'h0000_0000_FFFF_F800, 3'd0, 1'b0, 1'b0}); // jalr -2048
    vecs.push_back('{32'h0010809B, 64'h0000_0000_0000_0000, 3'd7, 1'b1, 1'b0}); // addiw on RV32
    vecs.push_back('{32'h0000007F, 64'h0000_0000_0000_0000, 3'd7, 1'b1, 1'b0}); // unknown
`ifdef IMM_GEN_UJ_EN
    vecs.push_back('{32'h123452B7, 64'h0000_0000_1234_5000, 3'd3, 1'b0, 1'b0}); // lui
    vecs.push_back('{32'h008000EF, 64'h0000_0000_0000_0008, 3'd4, 1'b0, 1'b0}); // jal +8
    vecs.push_back('{32'h800002B7, 64'hFFFF_FFFF_8000_0000, 3'd3, 1'b0, 1'b1}); // lui, RV64 sext
`else
    vecs.push_back('{32'h123452B7, 64'h0, 3'd7, 1'b1, 1'b0});
    vecs.push_back('{32'h008000EF, 64'h0, 3'd7, 1'b1, 1'b0});
    vecs.push_back('{32'h800002B7, 64'h0, 3'd7, 1'b1, 1'b1});
`endif
    vecs.push_back('{32'h03F09093, 64'h0000_0000_0000_003F, 3'd0, 1'b0, 1'b1}); // slli 63
    vecs.push_back('{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b0, 1'b1}); // addi -1
    vecs.push_back('{32'hFE000CE3, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 1'b0, 1'b1}); // beq -8
    vecs.push_back('{32'h0210909B, 64'h0000_0000_0000_0001, 3'd0, 1'b0, 1'b1}); // slliw 5-bit
    vecs.push_back('{32'h0010809B, 64'h0000_0000_0000_0001, 3'd0, 1'b0, 1'b1}); // addiw 1
    vecs.push_back('{32'h0000007F, 64'h0,                   3'd7, 1'b1, 1'b1}); // unknown

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'b0, ov32}, 64'd0);
    chk("rst_in_ready", {63'b0, ir32}, 64'd1);
    chk("rst_out_imm", {32'b0, om32}, 64'd0);
    chk("rst_out_instr", {32'b0, oi32}, 64'd0);
    chk("rst_out_fmt", {61'b0, of32}, 64'd7);
    chk("rst_out_illegal", {63'b0, ill32}, 64'd0);
    chk("rst64_out_fmt", {61'b0, of64}, 64'd7);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- table-driven decode ----------------
    foreach (vecs[i]) apply(vecs[i], i);

    // ---------------- back-to-back throughput ----------------
    bp[0] = 32'hFFF00093; bp[1] = 32'hFE112E23; bp[2] = 32'hFE000CE3; bp[3] = 32'h4030D093;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      iv32 = 1'b1;
      ii32 = bp[i];
      @(posedge clk);
      #1;
      chk($sformatf("tp%0d_valid", i), {63'b0, ov32}, 64'd1);
      chk($sformatf("tp%0d_instr", i), {32'b0, oi32}, {32'b0, bp[i]});
      chk($sformatf("tp%0d_in_ready", i), {63'b0, ir32}, 64'd1);
    end
    @(negedge clk);
    iv32 = 1'b0;
    @(negedge clk);

    // ---------------- backpressure: stall with out_ready=0 ----------------
    or32 = 1'b0;
    idx  = 0;
    leak = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (idx < 4) begin iv32 = 1'b1; ii32 = bp[idx]; end
      else iv32 = 1'b0;
      if (idx >= 2 && ir32) leak = 1'b1;
      acc = iv32 && ir32;
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
    end
    chk("bp_accepted", 64'(idx), 64'd2);
    chk("bp_ready_low_leak", {63'b0, leak}, 64'd0);
    chk("bp_in_ready", {63'b0, ir32}, 64'd0);
    chk("bp_hold_instr", {32'b0, oi32}, {32'b0, bp[0]});
    chk("bp_hold_imm", {32'b0, om32}, 64'h0000_0000_FFFF_FFFF);

    // ---------------- backpressure: release and drain ----------------
    or32 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (idx < 4) begin iv32 = 1'b1; ii32 = bp[idx]; end
      else iv32 = 1'b0;
      acc = iv32 && ir32;
      if (ov32 && or32) got.push_back(oi32);
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
    end
    chk("drain_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) chk($sformatf("drain%0d_instr", i), {32'b0, got[i]}, {32'b0, bp[i]});
      else                chk($sformatf("drain%0d_instr", i), 64'hDEAD, {32'b0, bp[i]});
    end

    // ---------------- asynchronous reset with M and K full ----------------
    or32 = 1'b0;
    iv32 = 1'b1;
    ii32 = bp[0];
    @(posedge clk);
    @(negedge clk);
    ii32 = bp[1];
    @(posedge clk);
    @(negedge clk);
    iv32 = 1'b0;
    chk("full_out_valid", {63'b0, ov32}, 64'd1);
    chk("full_in_ready", {63'b0, ir32}, 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'b0, ov32}, 64'd0);
    chk("arst_in_ready", {63'b0, ir32}, 64'd1);
    chk("arst_out_fmt", {61'b0, of32}, 64'd7);
    chk("arst_out_instr", {32'b0, oi32}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    or32  = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ov32) stale = 1'b1;
    end
    chk("post_rst_no_stale", {63'b0, stale}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. Accepts one instruction per cycle on a valid/ready handshake, classifies its format (I/S/B/U/J), produces the sign-extended XLEN-bit immediate with a shift-amount special case, and flags unrecognised opcodes. A two-entry output/skid buffer gives full throughput under backpressure with a registered `in_ready`.

## Interface
- `XLEN`, 32: immediate width; legal values are 32 or 64.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input instruction valid.
- `in_ready`  out  1  block can accept; registered.
- `in_instr`  in  32  instruction word.
- `out_valid`  out  1  output holds a result.
- `out_ready`  in  1  consumer accepts the result.
- `out_instr`  out  32  instruction word passed through unchanged.
- `out_imm`  out  XLEN  generated immediate.
- `out_fmt`  out  3  format: 0 I, 1 S, 2 B, 3 U, 4 J, 7 none.
- `out_illegal`  out  1  opcode not recognised.

## Operation
- Opcode decode on `in_instr[6:0]`:
  - I: 0010011 (OP-IMM), 0000011 (LOAD), 1100111 (JALR), and 0011011 (OP-IMM-32, only when XLEN=64).
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
- Immediates, sign-extended from `instr[31]` to XLEN:
  - I: `instr[31:20]`.
  - S: `{instr[31:25], instr[11:7]}`.
  - B: `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`.
  - U: `{instr[31:12], 12'b0}`.
  - J: `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`.
- Shift special case: OP-IMM or OP-IMM-32 with funct3 001 or 101 yields a zero-extended shamt.
  - XLEN=32, and OP-IMM-32 at any XLEN: `instr[24:20]`.
  - XLEN=64 OP-IMM: `instr[25:20]`.
  - funct7 bits are never included.
- Unrecognised opcode: `out_imm`=0, `out_fmt`=7, `out_illegal`=1. The word is still passed downstream, never dropped.
- Buffering uses main output register M and skid register K, each with its own valid bit.
  - Accept occurs when `in_valid && in_ready`.
  - On accept, the decoded result goes to M if M is empty or M is being consumed (`out_valid && out_ready`) with K empty. Otherwise it goes to K.
  - When M is consumed and K is valid, K moves to M and K empties.
  - `in_ready` next = !(K valid next).
- Ordering is strictly preserved; no result is lost or duplicated.

## Timing
- Reset values: `out_valid`=0, `in_ready`=1, `out_imm`=0, `out_instr`=0, `out_fmt`=7, `out_illegal`=0; K valid=0.
- Latency: accept in cycle N gives `out_valid` in cycle N+1 when M is free.
- Throughput: 1 per cycle with `out_ready` held high.
- Backpressure:
  - First stalled accept fills K.
  - `in_ready` drops in the following cycle; no input is accepted while K is full.
  - `in_ready` returns 1 the cycle after K drains into M.
- Outputs hold stable while `out_valid && !out_ready`.
- Simultaneous accept and consume with K empty: the new word replaces M in the same edge, and `out_valid` stays 1.
- Reset asserted mid-operation clears M and K immediately (asynchronously); in-flight words are discarded.

## Configuration
- `IMM_GEN_UJ_EN` defined: U and J formats are decoded as above.
- `IMM_GEN_UJ_EN` not defined: U/J opcodes are treated as unrecognised (`out_fmt`=7, `out_illegal`=1, `out_imm`=0). I/S/B behaviour is unchanged.

## Test plan
- XLEN=32, `out_ready`=1:
  - 0xFFF00093 (addi -1) -> `out_imm` 0xFFFFFFFF, fmt 0, one cycle later.
  - 0xFE112E23 (sw -4) -> 0xFFFFFFFC, fmt 1.
  - 0xFE000CE3 (beq -8) -> 0xFFFFFFF8, fmt 2.
- Shift case: 0x4030D093 (srai 3) -> `out_imm` 3, not 0x403. With XLEN=64, 0x03F09093 (slli 63) -> 63.
- Macro `IMM_GEN_UJ_EN` defined:
  - 0x123452B7 (lui) -> 0x12345000, fmt 3.
  - 0x008000EF (jal +8) -> 8, fmt 4.
- Macro `IMM_GEN_UJ_EN` undefined: the same two words give fmt 7 and illegal=1. Opcode 0x0000007F gives illegal=1 at any setting.
- Backpressure:
  - Stream 4 words with `out_ready`=0 -> 2 accepted, and `in_ready`=0 from the cycle after the second accept.
  - Raise `out_ready` -> all 4 emerge in order, no loss and no duplication.
- Assert `rst_n`=0 with M and K both full -> `out_valid`=0 and `in_ready`=1 immediately. No stale word appears after release.
